// File: rtl/booth_radix4_seq_mul_pkg.sv
// Shared definitions for the radix-4 Booth sequential multiplier:
// Booth select codes and FSM state encoding.
package booth_radix4_seq_mul_pkg;

    localparam logic [2:0] BOOTH_m2A = 3'd1;
    localparam logic [2:0] BOOTH_mA  = 3'd2;
    localparam logic [2:0] BOOTH_0   = 3'd3;
    localparam logic [2:0] BOOTH_pA  = 3'd4;
    localparam logic [2:0] BOOTH_p2A = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/booth_radix4_seq_mul_enc.sv
// Radix-4 Booth encoder: maps one overlapping 3-bit multiplier window
// {b[2i+1], b[2i], b[2i-1]} to a partial-product select code.
module booth_radix4_seq_mul_enc
    import booth_radix4_seq_mul_pkg::*;
(
    input  logic [2:0] data,
    output logic [2:0] sel
);

    always_comb begin
        sel = BOOTH_0;
        case (data)
            3'b000:  sel = BOOTH_0;
            3'b001:  sel = BOOTH_pA;
            3'b010:  sel = BOOTH_pA;
            3'b011:  sel = BOOTH_p2A;
            3'b100:  sel = BOOTH_m2A;
            3'b101:  sel = BOOTH_mA;
            3'b110:  sel = BOOTH_mA;
            3'b111:  sel = BOOTH_0;
            default: sel = BOOTH_0;
        endcase
    end

endmodule

// File: rtl/booth_radix4_seq_mul.sv
// Sequential signed radix-4 Booth multiplier: one Booth digit retired per
// RUN cycle, start/busy/done handshake, product held until next completion.
module booth_radix4_seq_mul
    import booth_radix4_seq_mul_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int DIGITS = WIDTH / 2;
    localparam int CNT_W  = $clog2(DIGITS);
    localparam int PW     = WIDTH + 2;
    localparam int AW     = 2 * WIDTH;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIGITS - 1);

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [AW-1:0]      acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [AW-1:0]      product_q, product_d;

    logic [WIDTH:0]     b_shr;
    logic [2:0]         digit;
    logic [2:0]         sel;
    logic [PW-1:0]      a_ext;
    logic [PW-1:0]      pp;
    logic [AW-1:0]      pp_ext;
    logic [AW-1:0]      acc_sum;

    // b[-1] = 0 is supplied by the appended zero; digit i sits at bit 2i.
    always_comb begin
        b_shr = {b_q, 1'b0} >> {cnt_q, 1'b0};
        digit = b_shr[2:0];
    end

    booth_radix4_seq_mul_enc u_enc (
        .data (digit),
        .sel  (sel)
    );

    always_comb begin
        a_ext = {{2{a_q[WIDTH-1]}}, a_q};
        pp    = '0;
        case (sel)
            BOOTH_m2A: pp = ~(a_ext << 1) + PW'(1);
            BOOTH_mA:  pp = ~a_ext + PW'(1);
            BOOTH_0:   pp = '0;
            BOOTH_pA:  pp = a_ext;
            BOOTH_p2A: pp = a_ext << 1;
            default:   pp = '0;
        endcase
        pp_ext  = {{(AW-PW){pp[PW-1]}}, pp};
        acc_sum = acc_q + (pp_ext << {cnt_q, 1'b0});
    end

    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        product_d = product_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                if (start) begin
                    state_d = ST_RUN;
                    a_d     = a;
                    b_d     = b;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            ST_RUN: begin
                acc_d = acc_sum;
                if (cnt_q == LAST) begin
                    state_d   = ST_DONE;
                    product_d = acc_sum;
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            product_q <= product_d;
        end
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign product = product_q;

endmodule

// File: tb/tb_booth_radix4_seq_mul.sv
// Randomised scoreboard bench for booth_radix4_seq_mul (WIDTH=8) against an
// integer-arithmetic reference model.
module tb_booth_radix4_seq_mul;

    localparam int W = 8;

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic            start = 1'b0;
    logic [W-1:0]    a = '0;
    logic [W-1:0]    b = '0;
    logic            busy;
    logic            done;
    logic [2*W-1:0]  product;

    int              checks = 0;
    int              errors = 0;
    logic [2*W-1:0]  exp_q[$];
    logic [2*W-1:0]  last_prod = '0;

    always #5 clk = ~clk;

    booth_radix4_seq_mul #(.WIDTH(W)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] x, input logic [W-1:0] y);
        int sx;
        int sy;
        sx = int'($signed(x));
        sy = int'($signed(y));
        return (2*W)'(sx * sy);
    endfunction

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Monitor: pops on every done pulse, otherwise the product must hold.
    always @(negedge clk) begin
        if (!reset_n) begin
            last_prod = '0;
        end else begin
            checks++;
            if (busy && done) begin
                errors++;
                $display("FAIL busy_done_overlap: busy=%b done=%b", busy, done);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: product %h with empty scoreboard", product);
                end else begin
                    check("product", product, exp_q.pop_front());
                end
                last_prod = product;
            end else begin
                check("product_hold", product, last_prod);
            end
        end
    end

    task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(ref_mul(x, y));
        #1;
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
    endtask

    task automatic wait_done(input string name, input int exp_busy);
        int  nb;
        bit  seen;
        nb = 0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nb++;
        end
        checks++;
        if (!seen || nb != exp_busy) begin
            errors++;
            $display("FAIL %s_latency: busy cycles %0d done seen %0d, required %0d busy cycles then done",
                     name, nb, seen, exp_busy);
        end
    endtask

    task automatic run_one(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                           input logic [2*W-1:0] req);
        issue(x, y);
        wait_done(name, W/2);
        check(name, product, req);
    endtask

    task automatic back_to_back(input int n);
        logic [W-1:0] x;
        logic [W-1:0] y;
        int           gap;
        bit           seen;
        x = W'($urandom);
        y = W'($urandom);
        @(negedge clk);
        a = x;
        b = y;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(ref_mul(x, y));
        for (int k = 0; k < n; k++) begin
            #1;
            a = W'($urandom);
            b = W'($urandom);
            gap = 0;
            seen = 1'b0;
            for (int j = 0; j < 20; j++) begin
                @(negedge clk);
                gap++;
                if (done) begin
                    seen = 1'b1;
                    break;
                end
            end
            checks++;
            if (!seen || gap != W/2 + 1) begin
                errors++;
                $display("FAIL throughput: result %0d interval %0d seen %0d, required %0d", k, gap, seen, W/2 + 1);
                start = 1'b0;
                return;
            end
            if (k < n - 1) begin
                x = W'($urandom);
                y = W'($urandom);
                a = x;
                b = y;
                @(posedge clk);
                exp_q.push_back(ref_mul(x, y));
            end
        end
        start = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [W-1:0] corners[6];
        corners = '{8'h80, 8'h7F, 8'hFF, 8'h00, 8'h01, 8'h81};

        repeat (2) @(negedge clk);
        check("reset_busy", {15'd0, busy}, 16'd0);
        check("reset_done", {15'd0, done}, 16'd0);
        check("reset_product", product, 16'd0);
        reset_n = 1'b1;

        run_one("t1", 8'd3, 8'd5, 16'h000F);
        run_one("t2_mm", 8'h80, 8'h80, 16'h4000);
        run_one("t2_mp", 8'h80, 8'h7F, 16'hC080);
        run_one("t2_np", 8'hFF, 8'h7F, 16'hFF81);
        run_one("t3_a0", 8'h00, 8'hB3, 16'h0000);
        run_one("t3_b0", 8'd93, 8'h00, 16'h0000);

        // Start pulse in the middle of a run must not disturb it.
        issue(8'd11, 8'hF9);
        fork
            begin
                repeat (2) @(negedge clk);
                a = 8'd100;
                b = 8'd100;
                start = 1'b1;
                @(negedge clk);
                start = 1'b0;
            end
        join_none
        wait_done("t4_ignore", W/2);
        check("t4_ignore", product, 16'hFFB3);

        back_to_back(6);
        repeat (3) @(negedge clk);

        issue(8'd77, 8'd55);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("t5_busy", {15'd0, busy}, 16'd0);
        check("t5_done", {15'd0, done}, 16'd0);
        check("t5_product", product, 16'd0);
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        #1;
        reset_n = 1'b1;
        run_one("t5_after", 8'hF6, 8'd12, 16'hFF88);

        foreach (corners[i]) begin
            foreach (corners[j]) begin
                run_one("corner", corners[i], corners[j], ref_mul(corners[i], corners[j]));
            end
        end

        back_to_back(1500);
        repeat (4) @(negedge clk);
        check("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
